muxn_reg: RTL and testbench
===========================

Name: muxn_reg

Overview:
- Parametrised successor to the combinational 2:1 mux in the MIPS datapath library.
- Selects one of N input channels, each WIDTH bits wide, and registers the result in a single output stage.
- Each input and the output use a valid/ready handshake.
- Two selection modes:
  - fixed select, driven by a select port;
  - round-robin arbitration among valid channels.
- Intended for merging multiple writeback/result sources into one pipelined bus.

Parameters:
- N, 4, number of input channels (2..16).
- WIDTH, 32, data width per channel.
- SELW, $clog2(N), select/channel-index width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  channel i presents data.
- in_ready  out  N  channel i word accepted this cycle.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SELW  channel index used when mode = 0.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  downstream accepts the word.
- out_chan  out  SELW  index of the channel that produced out_data.

Behaviour:
- Reset: synchronous, active-high; `rst` sampled on posedge clk. Values after reset:
  - out_valid = 0, out_data = 0, out_chan = 0;
  - round-robin pointer rr_ptr = 0;
  - in_ready = 0 (combinational, forced low while rst = 1).
- Reset mid-operation: any held output word is discarded, with no drain. rr_ptr returns to 0.
- load_en = ~out_valid | out_ready (output slot empty, or being drained this cycle).
- Grant in fixed mode (mode = 0):
  - grant = sel if in_valid[sel] = 1;
  - otherwise no grant.
  - If sel >= N (N not a power of two): no grant, and in_ready stays all 0.
- Grant in round-robin mode (mode = 1):
  - grant = first i with in_valid[i] = 1, searching rr_ptr, rr_ptr+1, ... N-1, 0, ... rr_ptr-1 (wrap at N);
  - no grant if in_valid = 0.
- Handshake:
  - in_ready[i] = load_en & grant_valid & (grant == i), combinational.
  - At most one in_ready bit is high per cycle.
  - Inputs must hold in_data/in_valid stable until in_ready.
  - The block never asserts in_ready to a channel with in_valid = 0.
- Posedge update when load_en & grant_valid:
  - out_data <= channel[grant];
  - out_chan <= grant;
  - out_valid <= 1.
- Posedge update when load_en & ~grant_valid: out_valid <= 0 (out_data/out_chan hold their last values).
- Stall (out_valid & ~out_ready): out_data, out_chan and out_valid hold; no in_ready asserted.
- Latency and throughput:
  - 1 cycle from input acceptance to out_valid.
  - Sustained 1 word/cycle when out_ready is held high (drain and load in the same cycle).
- rr_ptr:
  - <= (grant + 1) mod N on each accepted transfer in mode 1;
  - unchanged in mode 0 and on cycles with no acceptance.
- Mode or sel changes:
  - sampled combinationally; take effect on the next arbitration cycle;
  - never disturb a word already held in the output register.
- Boundaries:
  - N = 2 with mode = 0 behaves as the 2:1 mux plus one register stage.
  - Single valid channel in round-robin mode is granted every cycle regardless of rr_ptr.

Decomposition:
- Package muxn_pkg holds:
  - mode constants MODE_FIXED = 1'b0, MODE_RR = 1'b1;
  - a function computing the rotated-priority first-one index for round-robin search.
- Sub-module rr_arbiter (parameters N; inputs req[N], ptr[SELW]; outputs gnt_idx, gnt_valid) is purely combinational.
- muxn_reg owns rr_ptr, the output register and the handshake logic.

Test Plan (N=4, WIDTH=8):
- Reset: rst = 1 for 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, out_chan = 0, in_ready = 0000; after release, first grant in round-robin is channel 0.
- Fixed select: mode = 0, sel = 2, in_data channel 2 = 8'hA5, in_valid = 0100, out_ready = 1 -> in_ready = 0100 in cycle k; out_data = A5, out_chan = 2, out_valid = 1 in cycle k+1. Changing sel = 3 with in_valid[3] = 0 -> no grant, out_valid drops to 0 next cycle.
- Round-robin fairness: mode = 1, in_valid = 1111 held, out_ready = 1, channel data 8'h10/11/12/13 -> out_chan sequence 0,1,2,3,0 on consecutive cycles with matching data; throughput 1 word/cycle.
- Round-robin skip and wrap: in_valid = 1001, rr_ptr = 1 -> grant 3, then 0, then 3; rr_ptr takes 0, 1, 0.
- Backpressure: out_valid = 1, out_data = 8'h11, out_ready = 0 for 3 cycles with in_valid = 1111 -> out_data/out_chan stable and in_ready = 0000 throughout; then out_ready = 1 -> drain and new load in the same cycle.
- Reset mid-stall: held word 8'h22 with out_ready = 0, assert rst for one cycle -> out_valid = 0, out_data = 0, rr_ptr = 0; the word is lost and never presented.

Source files
------------

// File: rtl/muxn_pkg.sv
// Shared definitions for the N-way registered mux: mode encodings and the
// rotated-priority search used by the round-robin arbiter.
package muxn_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int MAX_N    = 16;
    localparam int MAX_SELW = 4;

    typedef struct packed {
        logic                valid;
        logic [MAX_SELW-1:0] idx;
    } rr_pick_t;

    // First set bit of req[n-1:0], scanning ptr, ptr+1, ... and wrapping at n.
    function automatic rr_pick_t rr_first(
        input logic [MAX_N-1:0]    req,
        input int unsigned         n,
        input logic [MAX_SELW-1:0] ptr
    );
        rr_pick_t    pick;
        int unsigned idx;
        pick = '0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!pick.valid && (k < n) && req[idx[MAX_SELW-1:0]]) begin
                pick.valid = 1'b1;
                pick.idx   = idx[MAX_SELW-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr.
module rr_arbiter
    import muxn_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_valid
);

    rr_pick_t pick;

    always_comb begin
        pick = rr_first(MAX_N'(req), N, MAX_SELW'(ptr));
    end

    assign gnt_idx   = SELW'(pick.idx);
    assign gnt_valid = pick.valid;

endmodule

// File: rtl/muxn_reg.sv
// N-channel valid/ready mux with one output register stage; the source is
// either a fixed select or round-robin arbitration among valid channels.
module muxn_reg
    import muxn_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 32,
    localparam int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_chan
);

    logic [WIDTH-1:0] chan [N];
    logic [WIDTH-1:0] out_data_reg;
    logic [SELW-1:0]  out_chan_reg;
    logic             out_valid_reg;
    logic [SELW-1:0]  rr_ptr_reg;

    logic [SELW-1:0]  rr_idx;
    logic             rr_valid;
    logic             sel_ok;
    logic             fix_valid;
    logic [SELW-1:0]  grant;
    logic             grant_valid;
    logic             load_en;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_reg),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_valid)
    );

    // An out-of-range select (non power-of-two N) must never grant.
    assign sel_ok    = (int'(sel) < N);
    assign fix_valid = sel_ok & in_valid[sel];

    always_comb begin
        grant       = sel;
        grant_valid = fix_valid;
        if (mode == MODE_RR) begin
            grant       = rr_idx;
            grant_valid = rr_valid;
        end
    end

    assign load_en = ~out_valid_reg | out_ready;

    generate
        for (gi = 0; gi < N; gi++) begin : g_ready
            assign in_ready[gi] = ~rst & load_en & grant_valid & (grant == SELW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
            out_valid_reg <= 1'b0;
            rr_ptr_reg    <= '0;
        end else if (load_en) begin
            if (grant_valid) begin
                out_data_reg  <= chan[grant];
                out_chan_reg  <= grant;
                out_valid_reg <= 1'b1;
                if (mode == MODE_RR) begin
                    rr_ptr_reg <= (int'(grant) == N - 1) ? '0 : grant + 1'b1;
                end
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_chan  = out_chan_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_muxn_reg.sv
// Bench for muxn_reg (N=4, WIDTH=8): directed vector table, then randomized
// traffic against a behavioural model of the arbitration rules.
module tb_muxn_reg;

    localparam int N     = 4;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic             mode;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_chan;

    int checks = 0;
    int errors = 0;

    muxn_reg #(.N(N), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic        oready;
        logic [31:0] data;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [1:0]  exp_oc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic m, logic [1:0] s, logic [3:0] v, logic o,
                                logic [31:0] d, logic [3:0] er, logic eov,
                                logic [7:0] eod, logic [1:0] eoc);
        vec_t x;
        x.rst = r; x.mode = m; x.sel = s; x.valid = v; x.oready = o; x.data = d;
        x.exp_rdy = er; x.exp_ov = eov; x.exp_od = eod; x.exp_oc = eoc;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic m, input logic [1:0] s,
                         input logic [3:0] v, input logic o, input logic [31:0] d);
        rst = r; mode = m; sel = s; in_valid = v; out_ready = o; in_data = d;
    endtask

    // Model state
    logic       m_valid;
    logic [7:0] m_data;
    logic [1:0] m_chan;
    int         m_ptr;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] D, DA5, D22;
        D   = 32'h13121110;
        DA5 = 32'h13A51110;
        D22 = 32'h13221110;

        // Reset with all channels requesting, then round-robin fairness
        tbl.push_back(mk(1, 1, 0, 4'hF, 1, D, 4'h0, 0, 8'h00, 0));
        tbl.push_back(mk(1, 1, 0, 4'hF, 1, D, 4'h0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 0, 4'hF, 1, D, 4'h1, 1, 8'h10, 0));
        tbl.push_back(mk(0, 1, 0, 4'hF, 1, D, 4'h2, 1, 8'h11, 1));
        tbl.push_back(mk(0, 1, 0, 4'hF, 1, D, 4'h4, 1, 8'h12, 2));
        tbl.push_back(mk(0, 1, 0, 4'hF, 1, D, 4'h8, 1, 8'h13, 3));
        tbl.push_back(mk(0, 1, 0, 4'hF, 1, D, 4'h1, 1, 8'h10, 0));
        // Skip and wrap with channels 0 and 3, pointer starting at 1
        tbl.push_back(mk(0, 1, 0, 4'h9, 1, D, 4'h8, 1, 8'h13, 3));
        tbl.push_back(mk(0, 1, 0, 4'h9, 1, D, 4'h1, 1, 8'h10, 0));
        tbl.push_back(mk(0, 1, 0, 4'h9, 1, D, 4'h8, 1, 8'h13, 3));
        // Fixed select, then select of an idle channel
        tbl.push_back(mk(0, 0, 2, 4'h4, 1, DA5, 4'h4, 1, 8'hA5, 2));
        tbl.push_back(mk(0, 0, 3, 4'h4, 1, DA5, 4'h0, 0, 8'hA5, 2));
        // Backpressure for three cycles, then drain and load together
        tbl.push_back(mk(0, 0, 1, 4'hF, 1, D, 4'h2, 1, 8'h11, 1));
        tbl.push_back(mk(0, 1, 0, 4'hF, 0, D, 4'h0, 1, 8'h11, 1));
        tbl.push_back(mk(0, 1, 0, 4'hF, 0, D, 4'h0, 1, 8'h11, 1));
        tbl.push_back(mk(0, 1, 0, 4'hF, 0, D, 4'h0, 1, 8'h11, 1));
        tbl.push_back(mk(0, 1, 0, 4'hF, 1, D, 4'h1, 1, 8'h10, 0));
        // Reset while a word is stalled; pointer returns to 0
        tbl.push_back(mk(0, 0, 2, 4'h4, 1, D22, 4'h4, 1, 8'h22, 2));
        tbl.push_back(mk(1, 0, 2, 4'h4, 0, D22, 4'h0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 0, 4'hF, 1, D, 4'h1, 1, 8'h10, 0));
        // Lone valid channel granted regardless of pointer, then idle
        tbl.push_back(mk(0, 1, 0, 4'h4, 1, D, 4'h4, 1, 8'h12, 2));
        tbl.push_back(mk(0, 1, 0, 4'h4, 1, D, 4'h4, 1, 8'h12, 2));
        tbl.push_back(mk(0, 1, 0, 4'h0, 1, D, 4'h0, 0, 8'h12, 2));

        drive(1, 0, 0, 4'h0, 0, 32'h0);
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].mode, tbl[i].sel, tbl[i].valid, tbl[i].oready, tbl[i].data);
            @(negedge clk);
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
            @(posedge clk); #1;
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(tbl[i].exp_od));
            chk($sformatf("vec%0d out_chan", i), 32'(out_chan), 32'(tbl[i].exp_oc));
            $display("vec %0d: rst=%0b mode=%0b valid=%b ready=%b -> out_valid=%0b data=%h chan=%0d",
                     i, tbl[i].rst, tbl[i].mode, tbl[i].valid, in_ready, out_valid, out_data, out_chan);
        end

        // Randomized traffic checked against the model
        m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic        r, m, o, ld, gv;
            logic [1:0]  s;
            logic [3:0]  v, er;
            logic [31:0] d;
            int          g;
            r = (cyc == 0) || ($urandom_range(0, 39) == 0);
            m = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            v = 4'($urandom);
            o = ($urandom_range(0, 3) != 0);
            d = $urandom;
            drive(r, m, s, v, o, d);

            ld = !m_valid || o;
            gv = 0; g = 0;
            if (m) begin
                for (int k = 0; k < N; k++) begin
                    if (!gv && v[(m_ptr + k) % N]) begin
                        gv = 1; g = (m_ptr + k) % N;
                    end
                end
            end else if (v[s]) begin
                gv = 1; g = int'(s);
            end
            er = (!r && ld && gv) ? 4'(1 << g) : 4'h0;

            @(negedge clk);
            chk($sformatf("rnd%0d in_ready", cyc), 32'(in_ready), 32'(er));

            if (r) begin
                m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
            end else if (ld) begin
                if (gv) begin
                    m_valid = 1;
                    m_data  = d[g*8 +: 8];
                    m_chan  = 2'(g);
                    if (m) m_ptr = (g + 1) % N;
                    $display("rnd %0d: accept ch%0d data=%h mode=%0b", cyc, g, m_data, m);
                end else begin
                    m_valid = 0;
                end
            end

            @(posedge clk); #1;
            chk($sformatf("rnd%0d out_valid", cyc), 32'(out_valid), 32'(m_valid));
            chk($sformatf("rnd%0d out_data", cyc), 32'(out_data), 32'(m_data));
            chk($sformatf("rnd%0d out_chan", cyc), 32'(out_chan), 32'(m_chan));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
